vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator that supersedes the hard-coded 800×525 counters in the top level. It produces horizontal/vertical counters, sync pulses of configurable polarity, a data-enable, scaled "cell" coordinates for the paddle/ball/frame/text drawing blocks, and line/frame strobes. It runs from the system clock with a pixel clock-enable, and its sync/DE outputs carry a configurable delay so they align with downstream pixel pipelines.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- SCALE_SHIFT, 4, log2 of cell size in pixels
- PIPE_DLY, 0, extra pix_en-cycles of delay on hsync/vsync/de (0..4)
- CW, 12, counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- pix_en  in  1  pixel clock-enable; all state advances only when high
- x  out  CW  horizontal count h, 0..H_TOTAL-1
- y  out  CW  vertical count v, 0..V_TOTAL-1
- x_cell  out  CW-SCALE_SHIFT  x >> SCALE_SHIFT
- y_cell  out  CW-SCALE_SHIFT  y >> SCALE_SHIFT
- de  out  1  active video, delayed PIPE_DLY
- hsync  out  1  delayed PIPE_DLY
- vsync  out  1  delayed PIPE_DLY
- line_start  out  1  high while h==0, undelayed
- frame_start  out  1  high while h==0 and v==0, undelayed
- frame_cnt  out  16  frames completed (see Configuration)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Order per line: active, front porch, sync, back porch.
- When pix_en=1: h increments; at H_TOTAL-1, h wraps to 0 and v increments; at (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- When pix_en=0, all registers, including delay stages, hold.
- Undelayed decode: de_raw = h<H_ACTIVE && v<V_ACTIVE; hs_raw active when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC; vs_raw active for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC. Active level is HS_POL/VS_POL; inactive level is the inverse.
- Delay: de/hsync/vsync pass through PIPE_DLY pix_en-qualified stages. PIPE_DLY=0 means direct.
- Strobes are level signals aligned with x/y. Consumers qualify them with pix_en.
- Reset (rst=0 at a clk edge): h=v=0, and delay stages are cleared to de=0 and sync inactive. Reset overrides pix_en. After reset: x=y=0, x_cell=y_cell=0, line_start=frame_start=1. With PIPE_DLY>0, de stays 0 and syncs stay inactive until flushed. frame_cnt=0.
- Reset asserted mid-frame: the same values apply on the next edge; no partial-frame state survives.

## Timing
- All outputs are registered or decoded from registered state with no combinational path from inputs.
- x/y/cells/strobes change on the clk edge following a cycle with pix_en=1.
- de/hsync/vsync reflect the (h,v) from PIPE_DLY enabled cycles earlier.
- Sync widths are exactly H_SYNC enabled cycles and V_SYNC lines; hsync edges are independent of v.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined: frame_cnt increments by 1 (mod 2^16) on each enabled wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- VGA_TIMING_FRAME_CNT_EN undefined: the port remains and is tied to 0, and no counter logic is built.

## Structure
- The shared package vga_pkg holds default timing constants, H_TOTAL/V_TOTAL computation functions, and the cell-coordinate width function.
- Sub-module vga_delay_line: a 3-bit-wide, PIPE_DLY-deep, enable-qualified shift register with synchronous clear; it is a pass-through when depth is 0.

## Test plan
- Defaults, pix_en=1 constantly: the frame period is 420000 cycles. hsync is low exactly for h=656..751. vsync is low exactly for v=490..491. de is high for 640×480 cycles per frame.
- pix_en high 1 cycle in 4: the frame period is 1,680,000 clk cycles. Outputs are stable during pix_en=0 cycles.
- x=639, y=479 with SCALE_SHIFT=4: x_cell=39 and y_cell=29. x=640 must give de=0.
- PIPE_DLY=2: de rises 2 enabled cycles after x=0 on line 0 and falls 2 enabled cycles after x=640.
- Assert rst=0 at x=300, y=200 for 3 cycles, then release: next outputs are x=0, y=0, frame_start=1, de=0 (PIPE_DLY=2), hsync=1, frame_cnt=0.
- VGA_TIMING_FRAME_CNT_EN defined, run 3 frames: frame_cnt reads 1, 2, 3 at successive frame_start assertions. When undefined, it stays 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 timing constants,
// line/frame total helpers, cell-coordinate width helper and the 3-bit
// sync/data-enable bundle carried through the output delay line.
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF    = 640;
    localparam int unsigned H_FP_DEF        = 16;
    localparam int unsigned H_SYNC_DEF      = 96;
    localparam int unsigned H_BP_DEF        = 48;
    localparam int unsigned V_ACTIVE_DEF    = 480;
    localparam int unsigned V_FP_DEF        = 10;
    localparam int unsigned V_SYNC_DEF      = 2;
    localparam int unsigned V_BP_DEF        = 33;
    localparam int unsigned SCALE_SHIFT_DEF = 4;
    localparam int unsigned CW_DEF          = 12;

    // Video bundle that must stay aligned through the pixel pipeline.
    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
    } sync_bus_t;

    function automatic int unsigned h_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned cell_width(input int unsigned cw,
                                               input int unsigned shift);
        return cw - shift;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-qualified shift register for the de/hsync/vsync bundle.
// Ports: clk, rst (sync, active-low; loads CLR_VAL into every stage),
//        en (advance), din (undelayed bundle), dout (bundle DEPTH enables late).
// DEPTH=0 makes the block a plain wire.
module vga_delay_line
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH   = 0,
    parameter sync_bus_t   CLR_VAL = '0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  sync_bus_t din,
    output sync_bus_t dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, en};
            assign dout        = din;
        end else begin : g_pipe
            sync_bus_t stages [DEPTH];

            // Stage 0 takes the new sample; later stages shift on enable.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stages[i] <= CLR_VAL;
                    end
                end else if (en) begin
                    stages[0] <= din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Ports: clk, rst (sync, active-low), pix_en (pixel clock-enable);
//        x/y raster counters, x_cell/y_cell scaled coordinates,
//        de/hsync/vsync delayed by PIPE_DLY enabled cycles,
//        line_start/frame_start undelayed level strobes, frame_cnt.
// Build option: define VGA_TIMING_FRAME_CNT_EN to count completed frames;
// otherwise frame_cnt is tied to zero and no counter is built.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned H_FP        = H_FP_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_BP        = H_BP_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned V_FP        = V_FP_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_BP        = V_BP_DEF,
    parameter logic        HS_POL      = 1'b0,
    parameter logic        VS_POL      = 1'b0,
    parameter int unsigned SCALE_SHIFT = SCALE_SHIFT_DEF,
    parameter int unsigned PIPE_DLY    = 0,
    parameter int unsigned CW          = CW_DEF
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      pix_en,
    output logic [CW-1:0]                             x,
    output logic [CW-1:0]                             y,
    output logic [cell_width(CW, SCALE_SHIFT)-1:0]    x_cell,
    output logic [cell_width(CW, SCALE_SHIFT)-1:0]    y_cell,
    output logic                                      de,
    output logic                                      hsync,
    output logic                                      vsync,
    output logic                                      line_start,
    output logic                                      frame_start,
    output logic [15:0]                               frame_cnt
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_DE_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_DE_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SY_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SY_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SY_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SY_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

    // Idle bundle: blanked video with both syncs at their inactive level.
    localparam sync_bus_t IDLE = '{de: 1'b0, hsync: ~HS_POL, vsync: ~VS_POL};

    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          last_h;
    logic          last_v;
    sync_bus_t     raw;
    sync_bus_t     dly;

    assign last_h = (h == H_LAST);
    assign last_v = (v == V_LAST);

    // Raster counters: h wraps at end of line and carries into v.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h <= '0;
            v <= '0;
        end else if (pix_en) begin
            if (last_h) begin
                h <= '0;
                v <= last_v ? '0 : v + CW'(1);
            end else begin
                h <= h + CW'(1);
            end
        end
    end

    // Undelayed decode of the current raster position.
    always_comb begin
        raw       = IDLE;
        raw.de    = (h < H_DE_END) && (v < V_DE_END);
        raw.hsync = ((h >= H_SY_BEG) && (h < H_SY_END)) ? HS_POL : ~HS_POL;
        raw.vsync = ((v >= V_SY_BEG) && (v < V_SY_END)) ? VS_POL : ~VS_POL;
    end

    vga_delay_line #(
        .DEPTH   (PIPE_DLY),
        .CLR_VAL (IDLE)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_en),
        .din  (raw),
        .dout (dly)
    );

    assign x           = h;
    assign y           = v;
    assign x_cell      = h[CW-1:SCALE_SHIFT];
    assign y_cell      = v[CW-1:SCALE_SHIFT];
    assign de          = dly.de;
    assign hsync       = dly.hsync;
    assign vsync       = dly.vsync;
    assign line_start  = (h == '0);
    assign frame_start = (h == '0) && (v == '0);

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frames;

    // Counts enabled wraps from the last pixel of the frame back to (0,0).
    always_ff @(posedge clk) begin
        if (!rst) begin
            frames <= '0;
        end else if (pix_en && last_h && last_v) begin
            frames <= frames + 16'd1;
        end
    end

    assign frame_cnt = frames;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized scoreboard bench for vga_timing_gen on a reduced raster.
// The stimulus process drives pix_en/rst, advances a position-based
// reference model and queues the expected outputs; a negedge monitor pops
// and compares them against the DUT.
module tb_vga_timing_gen;

    localparam int unsigned HA  = 10;
    localparam int unsigned HFP = 2;
    localparam int unsigned HSW = 3;
    localparam int unsigned HBP = 2;
    localparam int unsigned VA  = 6;
    localparam int unsigned VFP = 1;
    localparam int unsigned VSW = 2;
    localparam int unsigned VBP = 1;
    localparam logic        HPOL = 1'b0;
    localparam logic        VPOL = 1'b1;
    localparam int unsigned SS   = 2;
    localparam int unsigned DLY  = 2;
    localparam int unsigned CWB  = 8;
    localparam int unsigned CLW  = CWB - SS;

    localparam int HT    = HA + HFP + HSW + HBP;
    localparam int VT    = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int NCYC  = 4000;

    typedef struct packed {
        logic [CWB-1:0] x;
        logic [CWB-1:0] y;
        logic [CLW-1:0] xc;
        logic [CLW-1:0] yc;
        logic           de;
        logic           hs;
        logic           vs;
        logic           ls;
        logic           fs;
        logic [15:0]    fc;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           pix_en;
    logic [CWB-1:0] x;
    logic [CWB-1:0] y;
    logic [CLW-1:0] x_cell;
    logic [CLW-1:0] y_cell;
    logic           de;
    logic           hsync;
    logic           vsync;
    logic           line_start;
    logic           frame_start;
    logic [15:0]    frame_cnt;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q [$];

    // Reference model state: enabled-cycle position within the frame,
    // completed frames, and recent raw (de,hs,vs) samples for the delay.
    int         pos;
    int         frames;
    logic [2:0] hist [$];

    vga_timing_gen #(
        .H_ACTIVE    (HA),
        .H_FP        (HFP),
        .H_SYNC      (HSW),
        .H_BP        (HBP),
        .V_ACTIVE    (VA),
        .V_FP        (VFP),
        .V_SYNC      (VSW),
        .V_BP        (VBP),
        .HS_POL      (HPOL),
        .VS_POL      (VPOL),
        .SCALE_SHIFT (SS),
        .PIPE_DLY    (DLY),
        .CW          (CWB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .x           (x),
        .y           (y),
        .x_cell      (x_cell),
        .y_cell      (y_cell),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] raw_of(input int p);
        int  hh;
        int  vv;
        logic d;
        logic hs;
        logic vs;
        hh = p % HT;
        vv = p / HT;
        d  = (hh < HA) && (vv < VA);
        hs = (hh >= HA + HFP && hh < HA + HFP + HSW) ? HPOL : ~HPOL;
        vs = (vv >= VA + VFP && vv < VA + VFP + VSW) ? VPOL : ~VPOL;
        return {d, hs, vs};
    endfunction

    function automatic logic [2:0] idle_bus();
        return {1'b0, ~HPOL, ~VPOL};
    endfunction

    task automatic model_reset();
        pos    = 0;
        frames = 0;
        hist.delete();
        for (int i = 0; i < DLY; i++) hist.push_back(idle_bus());
    endtask

    task automatic model_step();
        if (DLY > 0) begin
            hist.push_back(raw_of(pos));
            void'(hist.pop_front());
        end
        pos = pos + 1;
        if (pos == FRAME) begin
            pos    = 0;
            frames = frames + 1;
        end
    endtask

    function automatic exp_t model_out();
        exp_t       e;
        logic [2:0] b;
        int         hh;
        int         vv;
        hh   = pos % HT;
        vv   = pos / HT;
        b    = (DLY == 0) ? raw_of(pos) : hist[0];
        e.x  = CWB'(hh);
        e.y  = CWB'(vv);
        e.xc = CLW'(hh / (1 << SS));
        e.yc = CLW'(vv / (1 << SS));
        e.de = b[2];
        e.hs = b[1];
        e.vs = b[0];
        e.ls = (hh == 0);
        e.fs = (hh == 0) && (vv == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        e.fc = 16'(frames % 65536);
`else
        e.fc = 16'd0;
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: one expected record per clock edge, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("x",           16'(x),           16'(e.x));
            chk("y",           16'(y),           16'(e.y));
            chk("x_cell",      16'(x_cell),      16'(e.xc));
            chk("y_cell",      16'(y_cell),      16'(e.yc));
            chk("de",          16'(de),          16'(e.de));
            chk("hsync",       16'(hsync),       16'(e.hs));
            chk("vsync",       16'(vsync),       16'(e.vs));
            chk("line_start",  16'(line_start),  16'(e.ls));
            chk("frame_start", 16'(frame_start), 16'(e.fs));
            chk("frame_cnt",   frame_cnt,        e.fc);
        end
    end

    // Stimulus: continuous enable, then 1-in-4 enable, then random enable,
    // with a directed 3-cycle mid-frame reset and sparse random resets.
    initial begin
        model_reset();
        rst    = 1'b0;
        pix_en = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            if (!rst) model_reset();
            else if (pix_en) model_step();
            exp_q.push_back(model_out());
            #1;
            if (c < 3) begin
                rst = 1'b0;
            end else if (c >= 2000 && c < 2003) begin
                rst = 1'b0;
            end else if (c > 2500 && $urandom_range(0, 399) == 0) begin
                rst = 1'b0;
            end else begin
                rst = 1'b1;
            end
            if (c < 700)       pix_en = 1'b1;
            else if (c < 1600) pix_en = ((c % 4) == 0);
            else               pix_en = ($urandom_range(0, 99) < 70);
        end
        repeat (2) @(negedge clk);
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
